// File: rtl/line_buffer_feed_control_pkg.sv
// ============================================================================
// line_buffer_feed_control_pkg - shared state encoding and width helper. Rev 1.0
// ============================================================================
`default_nettype none

package line_buffer_feed_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } feed_state_t;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_buffer_feed_control.sv
// ============================================================================
// line_buffer_feed_control - credit-gated DMA pixel feed into the line buffers. Rev 1.0
// ============================================================================
`default_nettype none

module line_buffer_feed_control
    import line_buffer_feed_control_pkg::*;
#(
    parameter int PIXEL_SIZE   = 32,
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512,
    parameter int INIT_LINES   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [PIXEL_SIZE-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  i_intr,
    output logic [PIXEL_SIZE-1:0] o_pixel_data,
    output logic                  o_pixel_data_valid,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_tlast_err,
    output logic                  o_credit_err
);

    localparam int PIX_W       = cnt_width(IMAGE_WIDTH);
    localparam int CRD_W       = cnt_width(INIT_LINES + 1);
    localparam int LIN_W       = cnt_width(IMAGE_HEIGHT + 1);
    localparam int INIT_CREDIT = (INIT_LINES < IMAGE_HEIGHT) ? INIT_LINES : IMAGE_HEIGHT;

    localparam logic [PIX_W-1:0] LAST_PIX     = PIX_W'(IMAGE_WIDTH - 1);
    localparam logic [LIN_W-1:0] LAST_LINE    = LIN_W'(IMAGE_HEIGHT - 1);
    localparam logic [LIN_W-1:0] ALL_LINES    = LIN_W'(IMAGE_HEIGHT);
    localparam logic [LIN_W-1:0] START_GRANT  = LIN_W'(INIT_CREDIT);
    localparam logic [CRD_W-1:0] MAX_CREDIT   = CRD_W'(INIT_LINES);
    localparam logic [CRD_W-1:0] START_CREDIT = CRD_W'(INIT_CREDIT);

    feed_state_t      state;
    logic [PIX_W-1:0] pix_ctr;
    logic [LIN_W-1:0] line_ctr;
    logic [LIN_W-1:0] lines_granted;
    logic [CRD_W-1:0] credit;
    logic             intr_d;

    logic transfer;
    logic intr_rise;
    logic line_done;
    logic grant;

    // Ready depends on registers only, so DMA never sees a tvalid->tready path.
    assign s_axis_tready = (state == ST_STREAM) && (credit != '0);
    assign transfer      = s_axis_tvalid && s_axis_tready;
    assign intr_rise     = i_intr && !intr_d;
    assign line_done     = transfer && (pix_ctr == LAST_PIX);
    assign grant         = (state == ST_STREAM) && intr_rise && (lines_granted < ALL_LINES);
    assign o_busy        = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            pix_ctr            <= '0;
            line_ctr           <= '0;
            lines_granted      <= '0;
            credit             <= '0;
            intr_d             <= 1'b0;
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
            o_frame_done       <= 1'b0;
            o_tlast_err        <= 1'b0;
            o_credit_err       <= 1'b0;
        end else begin
            intr_d             <= i_intr;
            o_pixel_data_valid <= transfer;
            o_frame_done       <= 1'b0;
            if (transfer) begin
                o_pixel_data <= s_axis_tdata;
            end

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state         <= ST_STREAM;
                        credit        <= START_CREDIT;
                        lines_granted <= START_GRANT;
                        pix_ctr       <= '0;
                        line_ctr      <= '0;
                        o_tlast_err   <= 1'b0;
                        o_credit_err  <= 1'b0;
                    end
                end

                ST_STREAM: begin
                    if (transfer) begin
                        if (s_axis_tlast != (pix_ctr == LAST_PIX)) begin
                            o_tlast_err <= 1'b1;
                        end
                        pix_ctr <= (pix_ctr == LAST_PIX) ? '0 : pix_ctr + 1'b1;
                    end

                    if (line_done) begin
                        line_ctr <= line_ctr + 1'b1;
                        if (line_ctr == LAST_LINE) begin
                            state        <= ST_DONE;
                            o_frame_done <= 1'b1;
                        end
                    end

                    // A grant landing with a line completion nets to zero credit change.
                    // A saturated grant is dropped so lines_granted - line_ctr tracks credit.
                    if (grant) begin
                        if (line_done) begin
                            lines_granted <= lines_granted + 1'b1;
                        end else if (credit == MAX_CREDIT) begin
                            o_credit_err <= 1'b1;
                        end else begin
                            credit        <= credit + 1'b1;
                            lines_granted <= lines_granted + 1'b1;
                        end
                    end else if (line_done) begin
                        credit <= credit - 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_line_buffer_feed_control.sv
// ============================================================================
// tb_line_buffer_feed_control - directed scoreboard bench for the line feed. Rev 1.0
// ============================================================================
`default_nettype none

module tb_line_buffer_feed_control;

    localparam int PS = 32;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int IL = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_start;
    logic [PS-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic          i_intr;
    logic [PS-1:0] o_pixel_data;
    logic          o_pixel_data_valid;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_tlast_err;
    logic          o_credit_err;

    int            checks = 0;
    int            errors = 0;
    int            frame_done_cnt = 0;
    logic [31:0]   exp_q[$];

    line_buffer_feed_control #(
        .PIXEL_SIZE  (PS),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .INIT_LINES  (IL)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_start           (i_start),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tlast      (s_axis_tlast),
        .i_intr            (i_intr),
        .o_pixel_data      (o_pixel_data),
        .o_pixel_data_valid(o_pixel_data_valid),
        .o_busy            (o_busy),
        .o_frame_done      (o_frame_done),
        .o_tlast_err       (o_tlast_err),
        .o_credit_err      (o_credit_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented pixel must match the oldest accepted stimulus pixel.
    always @(negedge clk) begin
        if (reset_n && o_pixel_data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pix_unexpected: got %0d expected none at %0t", o_pixel_data, $time);
            end else begin
                check("pix_data", o_pixel_data, exp_q.pop_front());
            end
        end
        if (reset_n && o_frame_done) begin
            frame_done_cnt++;
            check("frame_done_with_last_pixel", 32'(o_pixel_data_valid), 32'd1);
        end
    end

    // Holds tvalid (optionally with gaps) until the block stops accepting or max_n pixels go.
    task automatic stream(input int first, input int max_n, input bit gaps,
                          input int bad_tlast, output int accepted);
        int idle;
        int budget;
        int idx;
        accepted = 0;
        idle     = 0;
        budget   = 0;
        while (idle < 12 && budget < 2000 && accepted < max_n) begin
            idx           = first + accepted;
            s_axis_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_axis_tdata  = 32'(idx);
            s_axis_tlast  = ((idx % W) == W - 1) || (idx == bad_tlast);
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) begin
                exp_q.push_back(s_axis_tdata);
                accepted++;
                idle = 0;
            end else if (!s_axis_tready) begin
                idle++;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic start_frame();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic intr_pulse(input int n);
        i_intr = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        i_intr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        reset_n       = 1'b0;
        i_start       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        i_intr        = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Mid-line asynchronous reset with a tlast error already latched.
        start_frame();
        stream(0, 10, 1'b0, 2, acc);
        check("pre_reset_accepted", 32'(acc), 32'd10);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'd10;
        #1;
        check("pre_reset_tready", 32'(s_axis_tready), 32'd1);
        check("pre_reset_valid", 32'(o_pixel_data_valid), 32'd1);
        check("pre_reset_tlast_err", 32'(o_tlast_err), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_pixel_data", o_pixel_data, 32'd0);
        check("rst_pixel_valid", 32'(o_pixel_data_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_frame_done", 32'(o_frame_done), 32'd0);
        check("rst_tlast_err", 32'(o_tlast_err), 32'd0);
        check("rst_credit_err", 32'(o_credit_err), 32'd0);
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Initial release of INIT_LINES lines.
        start_frame();
        stream(0, 1000, 1'b0, -1, acc);
        check("init_accepted", 32'(acc), 32'(IL * W));
        check("init_tready_low", 32'(s_axis_tready), 32'd0);
        check("init_busy", 32'(o_busy), 32'd1);

        // Each interrupt rise (level held several cycles) releases one line.
        intr_pulse(5);
        stream(IL * W, 1000, 1'b0, -1, acc);
        check("intr1_accepted", 32'(acc), 32'(W));
        check("intr1_tready_low", 32'(s_axis_tready), 32'd0);
        intr_pulse(5);
        stream((IL + 1) * W, 1000, 1'b0, -1, acc);
        check("intr2_accepted", 32'(acc), 32'(W));
        check("frame_done_pulses", 32'(frame_done_cnt), 32'd1);
        check("done_busy_low", 32'(o_busy), 32'd0);

        // Trailing interrupt in IDLE is ignored.
        intr_pulse(2);
        check("idle_intr_credit_err", 32'(o_credit_err), 32'd0);
        check("idle_intr_tready", 32'(s_axis_tready), 32'd0);
        check("clean_tlast_err", 32'(o_tlast_err), 32'd0);

        // Irregular tvalid plus a premature tlast on pixel 5.
        start_frame();
        check("restart_tlast_err_cleared", 32'(o_tlast_err), 32'd0);
        stream(0, 1000, 1'b1, 5, acc);
        check("gaps_accepted", 32'(acc), 32'(IL * W));
        check("tlast_err_set", 32'(o_tlast_err), 32'd1);
        check("tlast_err_busy", 32'(o_busy), 32'd1);

        // Interrupt rise coinciding with the last pixel of line 0, then an excess rise.
        do_reset();
        start_frame();
        stream(0, W - 1, 1'b0, -1, acc);
        check("sim_pre_accepted", 32'(acc), 32'(W - 1));
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'(W - 1);
        s_axis_tlast  = 1'b1;
        i_intr        = 1'b1;
        @(negedge clk);
        check("sim_tready", 32'(s_axis_tready), 32'd1);
        if (s_axis_tready) exp_q.push_back(s_axis_tdata);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_intr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sim_credit_err_clear", 32'(o_credit_err), 32'd0);
        intr_pulse(3);
        check("sat_credit_err", 32'(o_credit_err), 32'd1);
        stream(W, 1000, 1'b0, -1, acc);
        check("sat_accepted", 32'(acc), 32'(IL * W));
        check("sat_tready_low", 32'(s_axis_tready), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
